// File: rtl/micro_tile_mux_seq_if.sv
// Tile-side bus of the micro-tile container: broadcasts, per-tile reset/enable
// and the packed per-tile pad outputs (tile k occupies bits [8k+7:8k]).
interface micro_tile_mux_seq_if #(
    parameter int N_TILES = 8
);
    logic [7:0]           tile_ui_in;
    logic [7:0]           tile_uio_in;
    logic [N_TILES-1:0]   tile_rst_n;
    logic [N_TILES-1:0]   tile_ena;
    logic [8*N_TILES-1:0] tile_uo_out;
    logic [8*N_TILES-1:0] tile_uio_out;
    logic [8*N_TILES-1:0] tile_uio_oe;

    modport master (
        output tile_ui_in, tile_uio_in, tile_rst_n, tile_ena,
        input  tile_uo_out, tile_uio_out, tile_uio_oe
    );

    modport slave (
        input  tile_ui_in, tile_uio_in, tile_rst_n, tile_ena,
        output tile_uo_out, tile_uio_out, tile_uio_oe
    );
endinterface

// File: rtl/micro_tile_mux_seq.sv
// Micro-tile container: latches a tile index during reset, sequences that tile
// out of reset, and routes its outputs to the pads with park/resume and fault.
module micro_tile_mux_seq #(
    parameter int N_TILES    = 8,
    parameter int SEL_W      = 3,
    parameter int RST_CYCLES = 4,
    parameter int REG_OUT    = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_ena,
    input  logic [7:0]              i_ui_in,
    input  logic [7:0]              i_uio_in,
    output logic [7:0]              o_uo_out,
    output logic [7:0]              o_uio_out,
    output logic [7:0]              o_uio_oe,
    micro_tile_mux_seq_if.master    tiles,
    output logic [SEL_W-1:0]        o_sel_active,
    output logic                    o_fault
);
    localparam int CNT_W = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_HOLD,
        ST_RUN,
        ST_PARK,
        ST_FAULT
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [SEL_W-1:0]   r_sel;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cntNext;
    logic               w_selValid;
    logic [N_TILES-1:0] w_hit;
    logic               w_live;
    logic [7:0]         w_uo;
    logic [7:0]         w_uio;
    logic [7:0]         w_oe;

    // The select keeps tracking ui_in for as long as reset is held low.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_RESET;
            r_sel   <= i_ui_in[SEL_W-1:0];
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cntNext;
        end
    end

    assign w_selValid = int'(r_sel) < N_TILES;

    always_comb begin
        w_next    = r_state;
        w_cntNext = r_cnt;
        case (r_state)
            ST_RESET: w_next = w_selValid ? ST_HOLD : ST_FAULT;
            ST_HOLD: begin
                if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
                    w_next = i_ena ? ST_RUN : ST_PARK;
                end else begin
                    w_cntNext = r_cnt + CNT_W'(1);
                end
            end
            ST_RUN:   if (!i_ena) w_next = ST_PARK;
            ST_PARK:  if (i_ena) w_next = ST_RUN;
            ST_FAULT: w_next = ST_FAULT;
            default:  w_next = ST_RESET;
        endcase
    end

    // An out-of-range select matches no tile, so every tile stays in reset.
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < N_TILES; k++) begin
            w_hit[k] = (r_sel == SEL_W'(k));
        end
    end

    always_comb begin
        tiles.tile_rst_n = '0;
        tiles.tile_ena   = '0;
        if (r_state == ST_RUN || r_state == ST_PARK) begin
            tiles.tile_rst_n = w_hit;
        end
        if ((r_state == ST_HOLD || r_state == ST_RUN) && i_ena) begin
            tiles.tile_ena = w_hit;
        end
    end

    assign tiles.tile_ui_in  = i_ui_in;
    assign tiles.tile_uio_in = i_uio_in;

    // Gating with rst_n lets the combinational pads drop on the reset cycle itself.
    assign w_live = (r_state == ST_RUN) && i_rst_n;

    always_comb begin
        w_uo  = '0;
        w_uio = '0;
        w_oe  = '0;
        if (w_live) begin
            for (int k = 0; k < N_TILES; k++) begin
                if (w_hit[k]) begin
                    w_uo  = tiles.tile_uo_out[8*k +: 8];
                    w_uio = tiles.tile_uio_out[8*k +: 8];
                    w_oe  = tiles.tile_uio_oe[8*k +: 8];
                end
            end
        end
    end

    generate
        if (REG_OUT != 0) begin : g_regOut
            logic [7:0] r_uo;
            logic [7:0] r_uio;
            logic [7:0] r_oe;

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_uo  <= '0;
                    r_uio <= '0;
                    r_oe  <= '0;
                end else begin
                    r_uo  <= w_uo;
                    r_uio <= w_uio;
                    r_oe  <= w_oe;
                end
            end

            assign o_uo_out  = r_uo;
            assign o_uio_out = r_uio;
            assign o_uio_oe  = r_oe;
        end else begin : g_combOut
            assign o_uo_out  = w_uo;
            assign o_uio_out = w_uio;
            assign o_uio_oe  = w_oe;
        end
    endgenerate

    assign o_sel_active = r_sel;
    assign o_fault      = (r_state == ST_FAULT);
endmodule

// File: tb/tb_micro_tile_mux_seq.sv
// Bench for micro_tile_mux_seq: a registered 8-tile instance and a combinational
// 6-tile instance, both checked against a cycle-count based reference model.
module tb_micro_tile_mux_seq;
    localparam int RSTC = 4;
    localparam int NT   [2] = '{8, 6};
    localparam int REGO [2] = '{1, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN [2];
    logic        ena  [2];
    logic [7:0]  ui   [2];
    logic [7:0]  uio  [2];
    logic [63:0] tuo  [2];
    logic [63:0] tuio [2];
    logic [63:0] toe  [2];

    wire [7:0] uoW [2];
    wire [7:0] uioOutW [2];
    wire [7:0] uioOeW [2];
    wire [7:0] tRstN [2];
    wire [7:0] tEna [2];
    wire [7:0] bcUi [2];
    wire [7:0] bcUio [2];
    wire [2:0] selAct [2];
    wire       faultW [2];

    int testsRun = 0;
    int testsFailed = 0;

    micro_tile_mux_seq_if #(.N_TILES(8)) busA();
    micro_tile_mux_seq_if #(.N_TILES(6)) busB();

    micro_tile_mux_seq #(.N_TILES(8), .SEL_W(3), .RST_CYCLES(RSTC), .REG_OUT(1)) dutA (
        .i_clk(clk), .i_rst_n(rstN[0]), .i_ena(ena[0]), .i_ui_in(ui[0]), .i_uio_in(uio[0]),
        .o_uo_out(uoW[0]), .o_uio_out(uioOutW[0]), .o_uio_oe(uioOeW[0]), .tiles(busA),
        .o_sel_active(selAct[0]), .o_fault(faultW[0])
    );

    micro_tile_mux_seq #(.N_TILES(6), .SEL_W(3), .RST_CYCLES(RSTC), .REG_OUT(0)) dutB (
        .i_clk(clk), .i_rst_n(rstN[1]), .i_ena(ena[1]), .i_ui_in(ui[1]), .i_uio_in(uio[1]),
        .o_uo_out(uoW[1]), .o_uio_out(uioOutW[1]), .o_uio_oe(uioOeW[1]), .tiles(busB),
        .o_sel_active(selAct[1]), .o_fault(faultW[1])
    );

    assign busA.tile_uo_out  = tuo[0];
    assign busA.tile_uio_out = tuio[0];
    assign busA.tile_uio_oe  = toe[0];
    assign busB.tile_uo_out  = tuo[1][47:0];
    assign busB.tile_uio_out = tuio[1][47:0];
    assign busB.tile_uio_oe  = toe[1][47:0];
    assign tRstN[0] = busA.tile_rst_n;
    assign tRstN[1] = {2'b00, busB.tile_rst_n};
    assign tEna[0]  = busA.tile_ena;
    assign tEna[1]  = {2'b00, busB.tile_ena};
    assign bcUi[0]  = busA.tile_ui_in;
    assign bcUi[1]  = busB.tile_ui_in;
    assign bcUio[0] = busA.tile_uio_in;
    assign bcUio[1] = busB.tile_uio_in;

    // Reference model: edges since reset release, and whether ena was high on the
    // last edge once the hold period is over (that alone decides run vs park).
    int         mSel  [2];
    int         mCnt  [2];
    bit         mLive [2];
    logic [7:0] rUo   [2];
    logic [7:0] rUio  [2];
    logic [7:0] rOe   [2];

    function automatic bit selValid(int id);
        return mSel[id] < NT[id];
    endfunction

    function automatic bit isRunning(int id);
        return selValid(id) && (mCnt[id] >= RSTC + 1);
    endfunction

    function automatic logic [7:0] liveSlice(int id, logic [63:0] data);
        if (isRunning(id) && mLive[id] && rstN[id]) return data[8*mSel[id] +: 8];
        return 8'h00;
    endfunction

    function automatic logic [7:0] expPad(int id, int which);
        logic [63:0] d;
        if (REGO[id] != 0) return (which == 0) ? rUo[id] : (which == 1) ? rUio[id] : rOe[id];
        d = (which == 0) ? tuo[id] : (which == 1) ? tuio[id] : toe[id];
        return liveSlice(id, d);
    endfunction

    function automatic logic [7:0] expRstN(int id);
        return isRunning(id) ? 8'(1 << mSel[id]) : 8'h00;
    endfunction

    function automatic logic [7:0] expEna(int id);
        bit on;
        on = selValid(id) && mCnt[id] >= 1 && (mCnt[id] <= RSTC || mLive[id]) && ena[id];
        return on ? 8'(1 << mSel[id]) : 8'h00;
    endfunction

    function automatic logic expFault(int id);
        return !selValid(id) && mCnt[id] >= 1;
    endfunction

    always @(posedge clk) begin
        logic [7:0] nU, nIo, nOe;
        for (int id = 0; id < 2; id++) begin
            nU  = liveSlice(id, tuo[id]);
            nIo = liveSlice(id, tuio[id]);
            nOe = liveSlice(id, toe[id]);
            if (!rstN[id]) begin
                mSel[id]  = int'(ui[id][2:0]);
                mCnt[id]  = 0;
                mLive[id] = 1'b0;
                rUo[id]   = 8'h00;
                rUio[id]  = 8'h00;
                rOe[id]   = 8'h00;
            end else begin
                if (mCnt[id] <= RSTC) mCnt[id] = mCnt[id] + 1;
                if (mCnt[id] >= RSTC + 1) mLive[id] = ena[id];
                rUo[id]  = nU;
                rUio[id] = nIo;
                rOe[id]  = nOe;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(int id);
        tuo[id]  = {$urandom(), $urandom()};
        tuio[id] = {$urandom(), $urandom()};
        toe[id]  = {$urandom(), $urandom()};
        uio[id]  = 8'($urandom());
    endtask

    task automatic enterReset(int id, logic [7:0] sel, int n);
        rstN[id] = 1'b0;
        ui[id]   = sel;
        repeat (n) cyc();
        rstN[id] = 1'b1;
    endtask

    task automatic test_reset();
        for (int id = 0; id < 2; id++) begin
            rstN[id] = 1'b0;
            ena[id]  = 1'b1;
            ui[id]   = 8'($urandom());
            applyStimulus(id);
        end
        repeat (3) cyc();
        for (int id = 0; id < 2; id++) begin
            testsRun += 9;
            if (uoW[id] !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_uo id=%0d got=%h exp=00", id, uoW[id]); end
            if (uioOutW[id] !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_uio id=%0d got=%h exp=00", id, uioOutW[id]); end
            if (uioOeW[id] !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_oe id=%0d got=%h exp=00", id, uioOeW[id]); end
            if (tRstN[id] !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_trst id=%0d got=%h exp=00", id, tRstN[id]); end
            if (tEna[id] !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_tena id=%0d got=%h exp=00", id, tEna[id]); end
            if (faultW[id] !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_fault id=%0d got=%b exp=0", id, faultW[id]); end
            if (selAct[id] !== ui[id][2:0]) begin testsFailed++; $display("[TB] FAIL reset_sel id=%0d got=%0d exp=%0d", id, selAct[id], ui[id][2:0]); end
            if (bcUi[id] !== ui[id]) begin testsFailed++; $display("[TB] FAIL bcast_ui id=%0d got=%h exp=%h", id, bcUi[id], ui[id]); end
            if (bcUio[id] !== uio[id]) begin testsFailed++; $display("[TB] FAIL bcast_uio id=%0d got=%h exp=%h", id, bcUio[id], uio[id]); end
        end
    endtask

    task automatic test_basic_select();
        int riseEdge = -1;
        logic [7:0] prev;
        enterReset(0, 8'h02, 3);
        ena[0] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            cyc();
            if (riseEdge < 0 && tRstN[0][2] === 1'b1) riseEdge = e;
            ui[0] = 8'($urandom());
            applyStimulus(0);
            #1;
            testsRun += 4;
            if (tRstN[0] !== expRstN(0)) begin testsFailed++; $display("[TB] FAIL basic_trst e=%0d got=%h exp=%h", e, tRstN[0], expRstN(0)); end
            if (tEna[0] !== expEna(0)) begin testsFailed++; $display("[TB] FAIL basic_tena e=%0d got=%h exp=%h", e, tEna[0], expEna(0)); end
            if (uoW[0] !== expPad(0, 0)) begin testsFailed++; $display("[TB] FAIL basic_uo e=%0d got=%h exp=%h", e, uoW[0], expPad(0, 0)); end
            if (selAct[0] !== 3'd2) begin testsFailed++; $display("[TB] FAIL basic_sel e=%0d got=%0d exp=2", e, selAct[0]); end
        end
        testsRun++;
        if (riseEdge != RSTC + 1) begin testsFailed++; $display("[TB] FAIL basic_rise_edge got=%0d exp=%0d", riseEdge, RSTC + 1); end
        prev = tuo[0][23:16];
        cyc();
        testsRun++;
        if (uoW[0] !== prev) begin testsFailed++; $display("[TB] FAIL basic_latency got=%h exp=%h", uoW[0], prev); end
    endtask

    task automatic test_reselect();
        enterReset(0, 8'h05, 2);
        ena[0] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            cyc();
            applyStimulus(0);
            #1;
            testsRun += 3;
            if (tRstN[0][2] !== 1'b0) begin testsFailed++; $display("[TB] FAIL reselect_old_tile e=%0d got=%b exp=0", e, tRstN[0][2]); end
            if (selAct[0] !== 3'd5) begin testsFailed++; $display("[TB] FAIL reselect_sel e=%0d got=%0d exp=5", e, selAct[0]); end
            if (uoW[0] !== expPad(0, 0)) begin testsFailed++; $display("[TB] FAIL reselect_uo e=%0d got=%h exp=%h", e, uoW[0], expPad(0, 0)); end
            if (e <= RSTC + 1) begin
                testsRun++;
                if (uoW[0] !== 8'h00) begin testsFailed++; $display("[TB] FAIL reselect_quiet e=%0d got=%h exp=00", e, uoW[0]); end
            end
        end
    endtask

    task automatic test_park_resume();
        enterReset(0, 8'h01, 2);
        ena[0] = 1'b1;
        repeat (RSTC + 3) cyc();
        tuo[0][15:8] = 8'hA5;
        cyc();
        ena[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            testsRun += 3;
            if (uoW[0] !== expPad(0, 0)) begin testsFailed++; $display("[TB] FAIL park_uo k=%0d got=%h exp=%h", k, uoW[0], expPad(0, 0)); end
            if (tRstN[0] !== 8'h02) begin testsFailed++; $display("[TB] FAIL park_trst k=%0d got=%h exp=02", k, tRstN[0]); end
            if (tEna[0] !== 8'h00) begin testsFailed++; $display("[TB] FAIL park_tena k=%0d got=%h exp=00", k, tEna[0]); end
            if (k >= 2) begin
                testsRun++;
                if (uoW[0] !== 8'h00) begin testsFailed++; $display("[TB] FAIL park_quiet k=%0d got=%h exp=00", k, uoW[0]); end
            end
        end
        ena[0] = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            cyc();
            testsRun += 2;
            if (tRstN[0] !== 8'h02) begin testsFailed++; $display("[TB] FAIL resume_trst k=%0d got=%h exp=02", k, tRstN[0]); end
            if (uoW[0] !== expPad(0, 0)) begin testsFailed++; $display("[TB] FAIL resume_uo k=%0d got=%h exp=%h", k, uoW[0], expPad(0, 0)); end
        end
        testsRun++;
        if (uoW[0] !== 8'hA5) begin testsFailed++; $display("[TB] FAIL resume_value got=%h exp=a5", uoW[0]); end
    endtask

    task automatic test_hold_ena_low();
        logic [7:0] sel;
        sel = 8'($urandom_range(7));
        enterReset(0, sel, 2);
        ena[0] = 1'b0;
        for (int e = 1; e <= RSTC + 3; e++) begin
            cyc();
            testsRun += 3;
            if (tEna[0] !== 8'h00) begin testsFailed++; $display("[TB] FAIL holdlow_tena e=%0d got=%h exp=00", e, tEna[0]); end
            if (uoW[0] !== 8'h00) begin testsFailed++; $display("[TB] FAIL holdlow_uo e=%0d got=%h exp=00", e, uoW[0]); end
            if (tRstN[0] !== expRstN(0)) begin testsFailed++; $display("[TB] FAIL holdlow_trst e=%0d got=%h exp=%h", e, tRstN[0], expRstN(0)); end
        end
        testsRun++;
        if (tRstN[0] !== 8'(1 << sel)) begin testsFailed++; $display("[TB] FAIL holdlow_parked_trst got=%h exp=%h", tRstN[0], 8'(1 << sel)); end
        ena[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            applyStimulus(0);
            #1;
            testsRun += 2;
            if (uoW[0] !== expPad(0, 0)) begin testsFailed++; $display("[TB] FAIL holdlow_resume_uo k=%0d got=%h exp=%h", k, uoW[0], expPad(0, 0)); end
            if (tEna[0] !== expEna(0)) begin testsFailed++; $display("[TB] FAIL holdlow_resume_tena k=%0d got=%h exp=%h", k, tEna[0], expEna(0)); end
        end
        testsRun++;
        if (tEna[0] !== 8'(1 << sel)) begin testsFailed++; $display("[TB] FAIL holdlow_live_tena got=%h exp=%h", tEna[0], 8'(1 << sel)); end
    endtask

    task automatic test_fault();
        ena[1] = 1'b1;
        enterReset(1, 8'h07, 2);
        for (int e = 1; e <= 6; e++) begin
            cyc();
            ui[1] = 8'($urandom());
            applyStimulus(1);
            #1;
            testsRun += 4;
            if (faultW[1] !== 1'b1) begin testsFailed++; $display("[TB] FAIL fault_flag e=%0d got=%b exp=1", e, faultW[1]); end
            if (tEna[1] !== 8'h00) begin testsFailed++; $display("[TB] FAIL fault_tena e=%0d got=%h exp=00", e, tEna[1]); end
            if (tRstN[1] !== 8'h00) begin testsFailed++; $display("[TB] FAIL fault_trst e=%0d got=%h exp=00", e, tRstN[1]); end
            if (uoW[1] !== 8'h00) begin testsFailed++; $display("[TB] FAIL fault_uo e=%0d got=%h exp=00", e, uoW[1]); end
        end
        rstN[1] = 1'b0;
        ui[1] = 8'h06;
        cyc();
        testsRun++;
        if (faultW[1] !== 1'b0) begin testsFailed++; $display("[TB] FAIL fault_clear got=%b exp=0", faultW[1]); end
        rstN[1] = 1'b1;
        cyc();
        testsRun++;
        if (faultW[1] !== 1'b1) begin testsFailed++; $display("[TB] FAIL fault_sel6 got=%b exp=1", faultW[1]); end
    endtask

    task automatic test_latency();
        enterReset(1, 8'h00, 2);
        ena[1] = 1'b1;
        repeat (RSTC + 2) cyc();
        toe[1][7:0] = 8'h00;
        #1;
        testsRun++;
        if (uioOeW[1] !== 8'h00) begin testsFailed++; $display("[TB] FAIL comb_oe_low got=%h exp=00", uioOeW[1]); end
        cyc();
        toe[1][7:0] = 8'hFF;
        #1;
        testsRun++;
        if (uioOeW[1] !== 8'hFF) begin testsFailed++; $display("[TB] FAIL comb_oe_same_cycle got=%h exp=ff", uioOeW[1]); end

        enterReset(0, 8'h00, 2);
        ena[0] = 1'b1;
        repeat (RSTC + 2) cyc();
        toe[0][7:0] = 8'h00;
        cyc();
        toe[0][7:0] = 8'hFF;
        #1;
        testsRun++;
        if (uioOeW[0] !== 8'h00) begin testsFailed++; $display("[TB] FAIL reg_oe_before got=%h exp=00", uioOeW[0]); end
        cyc();
        testsRun++;
        if (uioOeW[0] !== 8'hFF) begin testsFailed++; $display("[TB] FAIL reg_oe_after got=%h exp=ff", uioOeW[0]); end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 300; c++) begin
            cyc();
            for (int id = 0; id < 2; id++) begin
                rstN[id] = ($urandom_range(39) != 0);
                ena[id]  = ($urandom_range(7) != 0);
                ui[id]   = 8'($urandom());
                applyStimulus(id);
            end
            #1;
            for (int id = 0; id < 2; id++) begin
                testsRun += 7;
                if (uoW[id] !== expPad(id, 0)) begin testsFailed++; $display("[TB] FAIL rand_uo c=%0d id=%0d got=%h exp=%h", c, id, uoW[id], expPad(id, 0)); end
                if (uioOutW[id] !== expPad(id, 1)) begin testsFailed++; $display("[TB] FAIL rand_uio c=%0d id=%0d got=%h exp=%h", c, id, uioOutW[id], expPad(id, 1)); end
                if (uioOeW[id] !== expPad(id, 2)) begin testsFailed++; $display("[TB] FAIL rand_oe c=%0d id=%0d got=%h exp=%h", c, id, uioOeW[id], expPad(id, 2)); end
                if (tRstN[id] !== expRstN(id)) begin testsFailed++; $display("[TB] FAIL rand_trst c=%0d id=%0d got=%h exp=%h", c, id, tRstN[id], expRstN(id)); end
                if (tEna[id] !== expEna(id)) begin testsFailed++; $display("[TB] FAIL rand_tena c=%0d id=%0d got=%h exp=%h", c, id, tEna[id], expEna(id)); end
                if (faultW[id] !== expFault(id)) begin testsFailed++; $display("[TB] FAIL rand_fault c=%0d id=%0d got=%b exp=%b", c, id, faultW[id], expFault(id)); end
                if (selAct[id] !== 3'(mSel[id])) begin testsFailed++; $display("[TB] FAIL rand_sel c=%0d id=%0d got=%0d exp=%0d", c, id, selAct[id], mSel[id]); end
            end
        end
    endtask

    initial begin
        for (int id = 0; id < 2; id++) begin
            mSel[id] = 0;
            mCnt[id] = 0;
            mLive[id] = 1'b0;
            rUo[id] = 8'h00;
            rUio[id] = 8'h00;
            rOe[id] = 8'h00;
            rstN[id] = 1'b0;
            ena[id] = 1'b0;
            ui[id] = 8'h00;
        end
        test_reset();
        test_basic_select();
        test_reselect();
        test_park_resume();
        test_hold_ena_low();
        test_fault();
        test_latency();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
